claa_multiword_seq: RTL
=======================

Name: claa_multiword_seq

Overview:
- Sequential multi-precision adder/subtractor controller built around one shared CLAA instance (cascade_size, word_width).
- Adds or subtracts operands of word_width*word_count bits, one word_width chunk per clock, least significant chunk first, with the carry registered between chunks.
- Valid/ready handshakes on input and output so ALU-level sequencers can issue wide arithmetic without a wide combinational adder.

Parameters:
- cascade_size, 4, passed to CLAA; must divide word_width.
- word_width, 8, chunk width processed per cycle by CLAA.
- word_count, 4, number of chunks; full operand width W = word_width*word_count; word_count >= 1.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block can accept a request (IDLE only).
- SUB  in  1  0 = add, 1 = subtract; sampled at accept.
- C_IN  in  1  carry-in (add) or borrow-in (sub); sampled at accept.
- A  in  W  first operand; sampled at accept.
- B  in  W  second operand; sampled at accept.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer takes result.
- R  out  W  result.
- C_OUT  out  1  raw final carry (in sub mode, 1 = no borrow).
- OVF  out  1  signed two's-complement overflow.
- BUSY  out  1  high in RUN.

Behaviour:
- Clock and reset: one clock CLK; RESET is asynchronous and active-high.
- Reset state:
  - state = IDLE, IN_READY = 1, OUT_VALID = 0, BUSY = 0.
  - R = 0, C_OUT = 0, OVF = 0.
  - Chunk index and carry register = 0.
- FSM, IDLE -> RUN:
  - In IDLE, IN_READY = 1.
  - An edge with IN_VALID = 1 accepts the request.
  - On accept, latch A, latch Beff = SUB ? ~B : B, and set carry = C_IN ^ SUB.
  - Clear the chunk index and go to RUN.
- FSM, RUN:
  - Each cycle, CLAA receives A chunk[idx], Beff chunk[idx] and the carry register on its C_IN.
  - At the edge, the CLAA R output is stored into R chunk[idx], the CLAA C_OUT is stored into carry, and idx increments.
  - When idx == word_count-1 at the edge, go to DONE. C_OUT and OVF are written at that edge.
  - IN_READY = 0 throughout RUN.
- FSM, DONE -> IDLE:
  - In DONE, OUT_VALID = 1. R, C_OUT and OVF are stable.
  - At the edge where OUT_READY = 1, go to IDLE. OUT_VALID drops on that edge.
  - R, C_OUT and OVF hold their values until the next accept.
- Latency:
  - Accept at edge k gives OUT_VALID = 1 after edge k+word_count.
  - A new request can be accepted no earlier than the edge after the output handshake.
  - word_count = 1 gives a single RUN cycle.
- Arithmetic:
  - Add: R = (A + B + C_IN) mod 2^W; C_OUT = carry out of bit W-1.
  - Sub: R = (A - B - C_IN) mod 2^W, computed as A + ~B + ~C_IN; C_OUT = 1 when no borrow.
  - OVF = (A[W-1] == Beff[W-1]) && (R[W-1] != A[W-1]).
- Input handling: IN_VALID is ignored outside IDLE. A, B, SUB and C_IN may change freely after accept.
- Reset mid-operation: all state and outputs return to reset values immediately, the partial result is discarded, and IN_READY = 1 after reset release.
- IN_VALID and OUT_READY asserted together in DONE: only the output handshake occurs, and the new request is accepted in IDLE on the following edge.
- The CLAA P/G outputs are unused.

Test Plan:
- Configuration for all scenarios: word_width=8, word_count=4, cascade_size=4.
- Carry across chunks:
  - Stimulus: A=0x000000FF, B=0x00000001, SUB=0, C_IN=0.
  - Response: R=0x00000100, C_OUT=0, OVF=0; OUT_VALID rises exactly 4 edges after accept; BUSY high for 4 cycles.
- Full wrap:
  - A=0xFFFFFFFF, B=0x00000001 add -> R=0x00000000, C_OUT=1, OVF=0.
  - A=0x7FFFFFFF, B=0x00000001 add -> R=0x80000000, C_OUT=0, OVF=1.
- Subtract:
  - A=5, B=7, C_IN=0 -> R=0xFFFFFFFE, C_OUT=0, OVF=0.
  - A=0x80000000, B=1 -> R=0x7FFFFFFF, C_OUT=1, OVF=1.
  - A=10, B=3, C_IN=1 -> R=6, C_OUT=1.
- Backpressure:
  - Stimulus: hold OUT_READY=0 for 3 cycles in DONE while pulsing IN_VALID with new operands.
  - Response: OUT_VALID=1, R stable, IN_READY=0, request not taken.
  - Then raise OUT_READY: IDLE next edge, and the new request is accepted the edge after.
- Reset mid-RUN:
  - Stimulus: assert RESET asynchronously during chunk 2.
  - Response: all outputs return to reset values immediately, without waiting for a clock edge.
  - A following add 0x12345678 + 0x11111111 gives R=0x23456789.
- Random: 1000 back-to-back operations with random SUB, C_IN and OUT_READY stalls, compared against a W+1-bit reference model (R, C_OUT, OVF) with a PASS/FAIL error count.

Source files
------------

// File: rtl/claa_multiword_seq.sv
// Carry-lookahead adder slice: lookahead inside each cascade_size group, ripple between groups.
// Latency: purely combinational.
// Backpressure: none; the caller registers the carry between slices.
module claa #(
    parameter int cascade_size = 4,
    parameter int word_width   = 8
) (
    input  logic [word_width-1:0] A,
    input  logic [word_width-1:0] B,
    input  logic                  C_IN,
    output logic [word_width-1:0] R,
    output logic                  C_OUT
);
    localparam int GROUPS = word_width / cascade_size;

    logic [word_width-1:0] prop;
    logic [word_width-1:0] gen;
    logic [word_width:0]   carry;
    logic                  term;
    logic                  lookahead;

    // Each carry inside a group is formed directly from that group's carry-in.
    always_comb begin
        prop      = A ^ B;
        gen       = A & B;
        carry     = '0;
        term      = 1'b0;
        lookahead = 1'b0;
        carry[0]  = C_IN;
        for (int grp = 0; grp < GROUPS; grp++) begin
            for (int i = 1; i <= cascade_size; i++) begin
                term = carry[grp*cascade_size];
                for (int j = 0; j < i; j++) begin
                    term = term & prop[grp*cascade_size+j];
                end
                lookahead = term;
                for (int j = 0; j < i; j++) begin
                    term = gen[grp*cascade_size+j];
                    for (int k = j + 1; k < i; k++) begin
                        term = term & prop[grp*cascade_size+k];
                    end
                    lookahead = lookahead | term;
                end
                carry[grp*cascade_size+i] = lookahead;
            end
        end
        R     = prop ^ carry[word_width-1:0];
        C_OUT = carry[word_width];
    end
endmodule

// Multi-word add/subtract, one word_width chunk per clock through a shared CLAA, LSB chunk first.
// Latency: accept at edge k, OUT_VALID after edge k+word_count.
// Backpressure: result held in DONE until OUT_READY; no new request accepted outside IDLE.
module claa_multiword_seq #(
    parameter int cascade_size = 4,
    parameter int word_width   = 8,
    parameter int word_count   = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic                             SUB,
    input  logic                             C_IN,
    input  logic [word_width*word_count-1:0] A,
    input  logic [word_width*word_count-1:0] B,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [word_width*word_count-1:0] R,
    output logic                             C_OUT,
    output logic                             OVF,
    output logic                             BUSY
);
    localparam int W     = word_width * word_count;
    localparam int IDX_W = (word_count > 1) ? $clog2(word_count) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [W-1:0]           a_q;
    logic [W-1:0]           beff_q;
    logic [W-1:0]           r_q;
    logic                   carry_q;
    logic                   c_out_q;
    logic                   ovf_q;
    logic [IDX_W-1:0]       idx_q;

    logic [word_width-1:0]  a_chunk;
    logic [word_width-1:0]  b_chunk;
    logic [word_width-1:0]  sum_chunk;
    logic                   sum_carry;
    logic                   accept;
    logic                   last_chunk;

    assign accept     = (state_q == IDLE) && IN_VALID;
    assign last_chunk = (idx_q == IDX_W'(word_count - 1));
    assign a_chunk    = a_q[idx_q*word_width +: word_width];
    assign b_chunk    = beff_q[idx_q*word_width +: word_width];

    claa #(
        .cascade_size(cascade_size),
        .word_width  (word_width)
    ) u_claa (
        .A    (a_chunk),
        .B    (b_chunk),
        .C_IN (carry_q),
        .R    (sum_chunk),
        .C_OUT(sum_carry)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b0;
        case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtract folds into add: A + ~B with carry-in inverted, so C_OUT reads as "no borrow".
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_q     <= '0;
            beff_q  <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            beff_q  <= SUB ? ~B : B;
            carry_q <= C_IN ^ SUB;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            r_q[idx_q*word_width +: word_width] <= sum_chunk;
            carry_q <= sum_carry;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_chunk) begin
                c_out_q <= sum_carry;
                ovf_q   <= (a_q[W-1] == beff_q[W-1]) && (sum_chunk[word_width-1] != a_q[W-1]);
            end
        end
    end

    assign R     = r_q;
    assign C_OUT = c_out_q;
    assign OVF   = ovf_q;
endmodule
